// File: rtl/rr_mux_sched_if.sv
// Requester/consumer bundle for the round-robin mux scheduler.
interface rr_mux_sched_if #(
  parameter int unsigned DATA_W = 8
);
  logic [3:0]          req;
  logic [4*DATA_W-1:0] data_i;
  logic                out_ready;
  logic [3:0]          gnt;
  logic [1:0]          sel;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [1:0]          out_src;
  logic                busy;

  modport master (
    output req, data_i, out_ready,
    input  gnt, sel, out_valid, out_data, out_src, busy
  );

  modport slave (
    input  req, data_i, out_ready,
    output gnt, sel, out_valid, out_data, out_src, busy
  );
endinterface

// File: rtl/rr_mux_sched.sv
// Round-robin scheduler driving a registered 4:1 source mux; up to BURST_LEN
// beats per grant, presented downstream on a valid/ready output register.
module rr_mux_sched #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic           clk,
  input  logic           rst_b,
  rr_mux_sched_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, XFER} state_e;

  state_e              state_q, state_d;
  logic [3:0]          gnt_q, gnt_d;
  logic [1:0]          sel_q, sel_d;
  logic [1:0]          last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [1:0]          out_src_q, out_src_d;

  logic                found;
  logic [1:0]          win;
  logic [1:0]          idx;
  logic                can_load;
  logic                capture;
  logic [CNT_W-1:0]    cnt_inc;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      sel_q       <= '0;
      last_q      <= 2'd3;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    found       = 1'b0;
    win         = '0;
    idx         = '0;
    can_load    = !out_valid_q || bus.out_ready;
    capture     = 1'b0;
    cnt_inc     = cnt_q + CNT_W'(1);

    // Output register drains whenever the consumer takes the beat.
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        gnt_d = '0;
        // Rotating priority starting just after the previous winner.
        for (int k = 1; k <= 4; k++) begin
          idx = last_q + 2'(k);
          if (!found && bus.req[idx]) begin
            found = 1'b1;
            win   = idx;
          end
        end
        if (found) begin
          state_d = XFER;
          gnt_d   = 4'b0001 << win;
          sel_d   = win;
          last_d  = win;
          cnt_d   = '0;
        end
      end
      XFER: begin
        capture = bus.req[sel_q] && can_load;
        if (capture) begin
          out_data_d  = bus.data_i[sel_q*DATA_W +: DATA_W];
          out_src_d   = sel_q;
          out_valid_d = 1'b1;
          cnt_d       = cnt_inc;
          if (cnt_inc == CNT_W'(BURST_LEN)) begin
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
          end
        end else if (!bus.req[sel_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.busy      = (state_q == XFER);
endmodule

// File: tb/tb_rr_mux_sched.sv
// Bench for rr_mux_sched: two instances (BURST_LEN 4 and 1) driven in lockstep
// against a transaction-level reference model plus directed ordering checks.
module tb_rr_mux_sched;
  localparam int unsigned DW = 8;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] data = '0;
  logic        ready = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_mux_sched_if #(.DATA_W(DW)) bus0 ();
  rr_mux_sched_if #(.DATA_W(DW)) bus1 ();

  assign bus0.req = req;       assign bus1.req = req;
  assign bus0.data_i = data;   assign bus1.data_i = data;
  assign bus0.out_ready = ready; assign bus1.out_ready = ready;

  rr_mux_sched #(.DATA_W(DW), .BURST_LEN(4)) dut0 (.clk(clk), .rst_b(rst_b), .bus(bus0));
  rr_mux_sched #(.DATA_W(DW), .BURST_LEN(1)) dut1 (.clk(clk), .rst_b(rst_b), .bus(bus1));

  logic [3:0]    o_gnt [2];
  logic [1:0]    o_sel [2];
  logic          o_ov  [2];
  logic [DW-1:0] o_od  [2];
  logic [1:0]    o_src [2];
  logic          o_busy[2];
  assign o_gnt[0] = bus0.gnt;  assign o_gnt[1] = bus1.gnt;
  assign o_sel[0] = bus0.sel;  assign o_sel[1] = bus1.sel;
  assign o_ov[0]  = bus0.out_valid; assign o_ov[1] = bus1.out_valid;
  assign o_od[0]  = bus0.out_data;  assign o_od[1] = bus1.out_data;
  assign o_src[0] = bus0.out_src;   assign o_src[1] = bus1.out_src;
  assign o_busy[0] = bus0.busy;     assign o_busy[1] = bus1.busy;

  // Reference model: owner=-1 means no grant outstanding.
  int blen [2] = '{4, 1};
  int m_owner[2], m_last[2], m_cnt[2], m_sel[2], m_od[2], m_src[2];
  bit m_ov[2];

  int q0[$];
  int q1[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1; m_last[k] = 3; m_cnt[k] = 0; m_sel[k] = 0;
      m_ov[k] = 0; m_od[k] = 0; m_src[k] = 0;
    end
  endtask

  task automatic model_step();
    int w;
    bit nov;
    if (!rst_b) return;
    for (int k = 0; k < 2; k++) begin
      nov = m_ov[k] && !ready;
      if (m_owner[k] < 0) begin
        for (int s = 1; s <= 4; s++) begin
          w = (m_last[k] + s) % 4;
          if (m_owner[k] < 0 && req[w]) begin
            m_owner[k] = w; m_sel[k] = w; m_last[k] = w; m_cnt[k] = 0;
          end
        end
      end else begin
        w = m_owner[k];
        if (req[w] && (!m_ov[k] || ready)) begin
          m_od[k] = (data >> (w * DW)) & 32'hFF;
          m_src[k] = w;
          nov = 1;
          m_cnt[k]++;
          if (m_cnt[k] == blen[k]) m_owner[k] = -1;
        end else if (!req[w]) begin
          m_owner[k] = -1;
        end
      end
      m_ov[k] = nov;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("gnt%0d", k), 32'(o_gnt[k]), (m_owner[k] < 0) ? 32'd0 : (32'd1 << m_owner[k]));
      chk($sformatf("busy%0d", k), 32'(o_busy[k]), (m_owner[k] < 0) ? 32'd0 : 32'd1);
      chk($sformatf("sel%0d", k), 32'(o_sel[k]), 32'(m_sel[k]));
      chk($sformatf("valid%0d", k), 32'(o_ov[k]), 32'(m_ov[k]));
      chk($sformatf("data%0d", k), 32'(o_od[k]), 32'(m_od[k]));
      chk($sformatf("src%0d", k), 32'(o_src[k]), 32'(m_src[k]));
    end
  endtask

  task automatic tick();
    if (o_ov[0] && ready && rst_b) q0.push_back(int'(o_src[0]));
    if (o_ov[1] && ready && rst_b) q1.push_back(int'(o_src[1]));
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    data = $urandom;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (2) tick();
    @(negedge clk);
    rst_b = 1'b1;
    q0.delete();
    q1.delete();
  endtask

  initial begin
    model_reset();
    data = $urandom;
    do_reset();

    // Single requester, full bursts with a gap then regrant.
    req = 4'b0001; ready = 1'b1;
    tick();
    chk("s1_first_gnt", 32'(bus0.gnt), 32'h1);
    repeat (12) tick();

    // All requesting: rotation 0,1,2,3,0.
    do_reset();
    req = 4'b1111; ready = 1'b1;
    repeat (32) tick();
    chk("s2_beats", 32'(q0.size() >= 20), 32'd1);
    for (int i = 0; i < 20 && i < q0.size(); i++)
      chk($sformatf("s2_src[%0d]", i), 32'(q0[i]), 32'((i / 4) % 4));

    // Backpressure after first beat.
    do_reset();
    req = 4'b0100; ready = 1'b1;
    repeat (2) tick();
    ready = 1'b0;
    repeat (3) tick();
    ready = 1'b1;
    repeat (6) tick();

    // Early release and wrap-around.
    do_reset();
    req = 4'b0010; ready = 1'b1;
    repeat (3) tick();
    req = 4'b0000;
    tick();
    chk("s4_release", 32'(bus0.gnt), 32'h0);
    req = 4'b0011;
    tick();
    chk("s4_wrap", 32'(bus0.gnt), 32'h1);
    repeat (6) tick();

    // Asynchronous reset mid-burst.
    do_reset();
    req = 4'b1111; ready = 1'b1;
    repeat (3) tick();
    #2;
    rst_b = 1'b0;
    #1;
    chk("s5_gnt_async", 32'(bus0.gnt), 32'h0);
    chk("s5_valid_async", 32'(bus0.out_valid), 32'h0);
    chk("s5_data_async", 32'(bus0.out_data), 32'h0);
    model_reset();
    repeat (2) tick();
    @(negedge clk);
    rst_b = 1'b1;
    tick();
    chk("s5_regrant", 32'(bus0.gnt), 32'h1);
    repeat (4) tick();

    // Single-beat instance alternates between two requesters.
    do_reset();
    req = 4'b1010;
    for (int i = 0; i < 24; i++) begin
      ready = i[0] ? 1'b0 : 1'b1;
      tick();
    end
    chk("s6_beats", 32'(q1.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < q1.size(); i++)
      chk($sformatf("s6_src[%0d]", i), 32'(q1[i]), (i % 2 == 0) ? 32'd1 : 32'd3);

    // Randomised traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) do_reset();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
